// File: rtl/btn_debounce_arbiter_if.sv
// btn_debounce_arbiter_if: bundles the raw button inputs and the arbiter's
// press/held/busy/owner outputs plus a debug view of the FSM state.
// Handshake: there is no valid/ready pair here. press is a one-cycle
// strobe that is only meaningful in the cycle it is high, and held is a
// level that stays set from that strobe until the button is seen low.
interface btn_debounce_arbiter_if #(
    parameter int N_BTN = 4
);
    localparam int OW = $clog2(N_BTN);

    logic [N_BTN-1:0] B;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] held;
    logic             busy;
    logic [OW-1:0]    owner;
    logic             dbg_state;

    modport master (output B, input press, input held, input busy, input owner, input dbg_state);
    modport slave  (input B, output press, output held, output busy, output owner, output dbg_state);
endinterface

// File: rtl/btn_debounce_arbiter.sv
// btn_debounce_arbiter: N_BTN buttons share one debounce counter. An IDLE/COUNT
// FSM grants the counter round-robin to a pending button. That button must stay
// high for DB_CYCLES consecutive cycles before a one-cycle press pulse is
// emitted for it. Macro DBARB_SYNC_EN inserts a two-flop synchronizer on every
// button input. When the macro is not defined, the inputs are used directly.
module btn_debounce_arbiter #(
    parameter int DB_CYCLES = 20_000,
    parameter int N_BTN     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    btn_debounce_arbiter_if.slave   bus
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam int OW = $clog2(N_BTN);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    logic [N_BTN-1:0] s;
    logic [N_BTN-1:0] pend;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [N_BTN-1:0] held_q, held_d;
    logic [N_BTN-1:0] press_q, press_d;

    logic             grant_found;
    logic [OW-1:0]    grant_idx;
    int               cand;
    logic [OW-1:0]    cand_w;

`ifdef DBARB_SYNC_EN
    logic [N_BTN-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.B;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = bus.B;
`endif

    // A button is pending only while it is pressed and has not already been reported.
    assign pend = s & ~held_q;

    // Round-robin search. It begins one index after the last granted button.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_w      = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_BTN) cand = cand - N_BTN;
            cand_w = OW'(cand);
            if (!grant_found && pend[cand_w]) begin
                grant_found = 1'b1;
                grant_idx   = cand_w;
            end
        end
    end

    // Next-state logic. A release clears held at any time. The counter is only
    // compared for equality with the terminal value and is cleared on every grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        held_d  = held_q & s;
        press_d = '0;
        if (state_q == ST_IDLE) begin
            if (grant_found) begin
                owner_d = grant_idx;
                cnt_d   = '0;
                state_d = ST_COUNT;
            end
        end else begin
            if (!s[owner_q]) begin
                state_d = ST_IDLE;
                ptr_d   = owner_q;
            end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                press_d[owner_q] = 1'b1;
                held_d[owner_q]  = 1'b1;
                state_d          = ST_IDLE;
                ptr_d            = owner_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers. After reset, button 0 has first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= OW'(N_BTN - 1);
            held_q  <= '0;
            press_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            held_q  <= held_d;
            press_q <= press_d;
        end
    end

    assign bus.press     = press_q;
    assign bus.held      = held_q;
    assign bus.busy      = (state_q == ST_COUNT);
    assign bus.owner     = owner_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_btn_debounce_arbiter.sv
// tb_btn_debounce_arbiter: directed and random button traffic for
// btn_debounce_arbiter (DB_CYCLES=8, N_BTN=4). A reference model tracks the
// grant time of the current owner and the elapsed cycles since that grant.
module tb_btn_debounce_arbiter;
    localparam int DB = 8;
    localparam int N  = 4;
`ifdef DBARB_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    btn_debounce_arbiter_if #(.N_BTN(N)) bus ();

    btn_debounce_arbiter #(.DB_CYCLES(DB), .N_BTN(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    logic [N-1:0] m_held, m_press, m_s1, m_s2;
    bit           m_busy;
    int           m_owner, m_ptr, m_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Model one clock edge. Only the rules are modelled: a press happens when the
    // owner has stayed high for DB cycles since its grant, and grants go round-robin.
    task automatic model_edge(input logic [N-1:0] b, input logic r);
        logic [N-1:0] s, pend;
        bit found;
        int j;
        if (r) begin
            m_held = '0; m_press = '0; m_s1 = '0; m_s2 = '0;
            m_busy = 0; m_owner = 0; m_ptr = N - 1; m_start = 0;
            return;
        end
        if (SL != 0) begin
            s = m_s2; m_s2 = m_s1; m_s1 = b;
        end else begin
            s = b;
        end
        pend    = s & ~m_held;
        m_press = '0;
        m_held  = m_held & s;
        if (m_busy) begin
            if (!s[m_owner]) begin
                m_busy = 0; m_ptr = m_owner;
            end else if (cyc - m_start == DB) begin
                m_press[m_owner] = 1'b1;
                m_held[m_owner]  = 1'b1;
                m_busy = 0; m_ptr = m_owner;
            end
        end else begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && pend[j]) begin
                    found = 1; m_busy = 1; m_owner = j; m_start = cyc;
                end
            end
        end
    endtask

    // Drive inputs, clock one edge, update the model and compare all outputs.
    task automatic tick(input logic [N-1:0] b, input logic r);
        bus.B = b;
        rst   = r;
        @(posedge clk);
        cyc++;
        model_edge(b, r);
        #1;
        chk("press", 32'(bus.press), 32'(m_press));
        chk("held",  32'(bus.held),  32'(m_held));
        chk("busy",  32'(bus.busy),  32'(m_busy));
        chk("owner", 32'(bus.owner), 32'(m_owner));
    endtask

    // Hold inputs at b until press[idx] appears. The cycle count is checked against exp_lat.
    task automatic run_measure(input logic [N-1:0] b, input int idx, input int exp_lat);
        int  n;
        bit  seen;
        n = 0; seen = 0;
        while (!seen && n < exp_lat + 20) begin
            tick(b, 1'b0);
            n++;
            if (bus.press[idx]) seen = 1;
        end
        chk("latency", seen ? 32'(n) : 32'hffff_ffff, 32'(exp_lat));
    endtask

    initial begin
        logic [N-1:0] rb;
        bus.B = '0;

        // Reset
        tick('0, 1'b1);
        tick('0, 1'b1);
        chk("rst_press", 32'(bus.press), 0);
        chk("rst_busy",  32'(bus.busy),  0);
        tick('0, 1'b0);

        // Single button held steady: one pulse, then held until the release
        run_measure(4'b0001, 0, DB + 1 + SL);
        chk("held_set", 32'(bus.held[0]), 1);
        for (int i = 0; i < 12; i++) tick(4'b0001, 1'b0);
        for (int i = 0; i < 1 + SL; i++) tick(4'b0000, 1'b0);
        chk("held_clear", 32'(bus.held[0]), 0);
        for (int i = 0; i < 4; i++) tick('0, 1'b0);

        // A bounce aborts the first attempt, and the count restarts
        for (int i = 0; i < 5; i++) tick(4'b0001, 1'b0);
        tick(4'b0000, 1'b0);
        run_measure(4'b0001, 0, DB + 1 + SL);
        for (int i = 0; i < 3 + SL; i++) tick('0, 1'b0);

        // All four rise together from reset: round-robin order 0..3
        tick('0, 1'b1);
        for (int i = 0; i < N; i++)
            run_measure(4'b1111, i, (i == 0) ? DB + 1 + SL : DB + 1);
        for (int i = 0; i < 3 + SL; i++) tick('0, 1'b0);

        // Button 1 arrives while button 2 owns the counter
        for (int i = 0; i < 3; i++) tick(4'b0100, 1'b0);
        run_measure(4'b0110, 2, DB + 1 + SL - 3);
        tick(4'b0110, 1'b0);
        chk("handoff_busy",  32'(bus.busy),  1);
        chk("handoff_owner", 32'(bus.owner), 1);
        run_measure(4'b0110, 1, DB);
        for (int i = 0; i < 3 + SL; i++) tick('0, 1'b0);

        // Reset while the counter is at 4 discards the pending press
        for (int i = 0; i < 5 + SL; i++) tick(4'b1000, 1'b0);
        tick(4'b1000, 1'b1);
        chk("midrst_press", 32'(bus.press), 0);
        chk("midrst_busy",  32'(bus.busy),  0);
        chk("midrst_held",  32'(bus.held),  0);
        run_measure(4'b1000, 3, DB + 1 + SL);
        for (int i = 0; i < 3 + SL; i++) tick('0, 1'b0);

        // Random traffic: sparse toggles and an occasional reset
        rb = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(11) == 0) rb[i] = ~rb[i];
            tick(rb, ($urandom_range(399) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_debounce_arbiter.md
BTN_DEBOUNCE_ARBITER -- requirements
Module: btn_debounce_arbiter

Interface
REQ-001 Parameter DB_CYCLES, default 20_000: stable-high cycles required before a press is accepted; legal minimum 2.
REQ-002 Parameter N_BTN, default 4: number of button requesters sharing one debounce timer; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 B  input  N_BTN  raw button levels, asynchronous to clk, bouncy.
REQ-006 press  output  N_BTN  one-cycle pulse per accepted press, at most one bit set per cycle.
REQ-007 held  output  N_BTN  per-button latched flag: press reported, release not yet seen.
REQ-008 busy  output  1  high while the shared timer is owned (state COUNT).
REQ-009 owner  output  $clog2(N_BTN)  index of the current timer owner; holds its last value when not busy.

Function
REQ-010 Internal level s[i] is B[i] after the input stage of REQ-027/028; all rules below use s.
REQ-011 Pending set: pend[i] = s[i] & ~held[i].
REQ-012 FSM states IDLE and COUNT; one shared counter of width $clog2(DB_CYCLES).
REQ-013 IDLE, pend nonzero: grant by round-robin; search starts at index (ptr+1) mod N_BTN, where ptr is the last granted index. Load owner, clear counter, enter COUNT next cycle.
REQ-014 IDLE, pend zero: remain IDLE; counter and owner unchanged.
REQ-015 COUNT, s[owner]=0: abort; go to IDLE with no press pulse; ptr updates to owner.
REQ-016 COUNT, s[owner]=1 and counter < DB_CYCLES-1: increment counter, stay in COUNT.
REQ-017 COUNT, s[owner]=1 and counter = DB_CYCLES-1: next cycle press[owner]=1 and held[owner]=1; return to IDLE; ptr updates to owner.
REQ-018 Uncontended latency: press pulses exactly DB_CYCLES+1 cycles after the first cycle s[i]=1 is seen in IDLE.
REQ-019 Any bounce (s[owner]=0 for one cycle) during COUNT restarts the request from scratch through re-arbitration; the counter never resumes.
REQ-020 held[i] clears in the cycle after s[i]=0 is seen, independent of the FSM; release needs no debounce.
REQ-021 A button with held[i]=1 is never granted; holding a button produces exactly one press pulse.
REQ-022 Non-owner buttons requesting during COUNT wait; no request is lost while s stays high.
REQ-023 Re-grant from IDLE is allowed in the same cycle a press pulse is emitted; there are no dead cycles between owners.
REQ-024 Counter never wraps: it is compared for equality only and is cleared on every grant.

Reset
REQ-025 rst=1 at a clock edge: state=IDLE, counter=0, owner=0, ptr=N_BTN-1 (button 0 first priority), held=0, press=0, busy=0, synchronizer flops=0.
REQ-026 Reset in the middle of COUNT discards the pending press: no press pulse is emitted on or after the reset edge.

Configuration
REQ-027 DBARB_SYNC_EN defined: each B[i] passes through a two-flop synchronizer before it is used as s[i]; this adds 2 cycles to every latency in REQ-018 and REQ-020.
REQ-028 DBARB_SYNC_EN undefined: s[i]=B[i] directly; the integrator guarantees B is synchronous to clk.

Verification (DB_CYCLES=8, N_BTN=4, DBARB_SYNC_EN undefined)
REQ-029 B=0001 held steady -> press=0001 for exactly one cycle, 9 cycles after the rise; held[0]=1 until B[0]=0, then clears the next cycle; no further pulse.
REQ-030 B[0] high 5 cycles, low 1 cycle, high again -> no pulse from the first attempt; one pulse 9 cycles after the second rise.
REQ-031 B=1111 rising together from reset -> pulses in order 0,1,2,3, spaced 9 cycles apart, one bit per pulse.
REQ-032 B[2] held; B[1] rises during the count for button 2 -> press[2], then busy/owner=1 in the same cycle, then press[1] 9 cycles later.
REQ-033 rst pulsed at counter=4 while B[3] held -> outputs all 0 after reset; press[3] 9 cycles after reset deasserts.
REQ-034 Repeat REQ-029 with DBARB_SYNC_EN defined -> pulse at 11 cycles; held clears 3 cycles after the fall.
